// File: rtl/cop0_reg_bank.sv
// cop0_reg_bank: MIPS32 coprocessor-0 register bank. It commits exception reports, serves MTC0/MFC0 and ERET,
// runs Count/Compare and drives the exception vector, ERET target and interrupt request.
// Ports:
//   clk_i, reset_i                 clock, asynchronous active-high reset
//   exc_*_i                        exception report (happen, in_bd, code, epc, load_addr, badvaddr, load_ce, ce)
//   eret_i                         ERET commits this cycle
//   wr_en_i/wr_rd_i/wr_sel_i/wr_data_i   MTC0 write port
//   rd_rd_i/rd_sel_i -> rd_data_o  MFC0 combinational read port
//   hw_int_i                       hardware interrupt levels
//   ll_set_i/ll_addr_i             LL address capture
//   int_req_o, exc_vector_o, eret_target_o, kernel_mode_o   fetch-stage controls
//   status_o, epc_o, errorepc_o, ebase_o                    raw register values
module cop0_reg_bank #(
    parameter logic [9:0] CPU_NUMBER = 10'd0,
    parameter int         COUNT_DIV  = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        exc_happen_i,
    input  logic        exc_in_bd_i,
    input  logic [4:0]  exc_code_i,
    input  logic [31:0] exc_epc_i,
    input  logic        exc_load_addr_i,
    input  logic [31:0] exc_badvaddr_i,
    input  logic        exc_load_ce_i,
    input  logic [1:0]  exc_ce_i,
    input  logic        eret_i,
    input  logic        wr_en_i,
    input  logic [4:0]  wr_rd_i,
    input  logic [2:0]  wr_sel_i,
    input  logic [31:0] wr_data_i,
    input  logic [4:0]  rd_rd_i,
    input  logic [2:0]  rd_sel_i,
    output logic [31:0] rd_data_o,
    input  logic [5:0]  hw_int_i,
    input  logic        ll_set_i,
    input  logic [31:0] ll_addr_i,
    output logic        int_req_o,
    output logic [31:0] exc_vector_o,
    output logic [31:0] eret_target_o,
    output logic [31:0] status_o,
    output logic [31:0] epc_o,
    output logic [31:0] errorepc_o,
    output logic [31:0] ebase_o,
    output logic        kernel_mode_o
);
    localparam int             DW          = COUNT_DIV > 1 ? $clog2(COUNT_DIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST    = DW'(COUNT_DIV - 1);
    localparam logic [31:0]    STATUS_MASK = 32'hF040_FF17;
    localparam logic [31:0]    EBASE_MASK  = 32'h3FFF_F000;

    logic [31:0]   badvaddr_q, badvaddr_d, count_q, count_d, compare_q, compare_d;
    logic [31:0]   status_q, status_d, epc_q, epc_d, ebase_q, ebase_d;
    logic [31:0]   lladdr_q, lladdr_d, errorepc_q, errorepc_d;
    logic [DW-1:0] div_q, div_d;
    logic          bd_q, bd_d, ti_q, ti_d, iv_q, iv_d;
    logic [1:0]    ce_q, ce_d;
    logic [7:0]    ip_q, ip_d;
    logic [4:0]    code_q, code_d;
    logic [31:0]   cause;
    logic          exl, erl, div_wrap, inc;
    logic          wr_count, wr_compare, wr_status, wr_cause, wr_epc, wr_ebase, wr_errorepc;

    assign exl         = status_q[1];
    assign erl         = status_q[2];
    assign wr_count    = wr_en_i && wr_rd_i == 5'd9  && wr_sel_i == 3'd0;
    assign wr_compare  = wr_en_i && wr_rd_i == 5'd11 && wr_sel_i == 3'd0;
    assign wr_status   = wr_en_i && wr_rd_i == 5'd12 && wr_sel_i == 3'd0;
    assign wr_cause    = wr_en_i && wr_rd_i == 5'd13 && wr_sel_i == 3'd0;
    assign wr_epc      = wr_en_i && wr_rd_i == 5'd14 && wr_sel_i == 3'd0;
    assign wr_ebase    = wr_en_i && wr_rd_i == 5'd15 && wr_sel_i == 3'd1;
    assign wr_errorepc = wr_en_i && wr_rd_i == 5'd30 && wr_sel_i == 3'd0;
    assign div_wrap    = div_q == DIV_LAST;
    // An MTC0 Count restarts the divider, so that cycle never increments.
    assign inc         = div_wrap && !wr_count;

    assign cause = {bd_q, ti_q, ce_q, 4'd0, iv_q, 7'd0, ip_q, 1'b0, code_q, 2'd0};

    always_comb begin
        div_d       = (wr_count || div_wrap) ? '0 : div_q + DW'(1);
        count_d     = wr_count ? wr_data_i : count_q + 32'(inc);
        compare_d   = wr_compare ? wr_data_i : compare_q;
        // A Compare write clears TI even when the same edge would have matched.
        ti_d        = wr_compare ? 1'b0 : (inc && count_d == compare_q) ? 1'b1 : ti_q;
        // Hardware IP bits are resampled every cycle; only IP[1:0] are software state.
        ip_d        = {ti_q | hw_int_i[5], hw_int_i[4:0], (wr_cause && !exc_happen_i) ? wr_data_i[9:8] : ip_q[1:0]};
        iv_d        = (wr_cause && !exc_happen_i) ? wr_data_i[23] : iv_q;
        status_d    = exc_happen_i ? (status_q | 32'h2) :
                      eret_i       ? (status_q & (erl ? ~32'h4 : ~32'h2)) :
                      wr_status    ? (wr_data_i & STATUS_MASK) : status_q;
        // Nested exceptions keep the EPC/BD of the outermost fault.
        epc_d       = exc_happen_i ? (exl ? epc_q : exc_epc_i) : wr_epc ? wr_data_i : epc_q;
        bd_d        = (exc_happen_i && !exl) ? exc_in_bd_i : bd_q;
        code_d      = exc_happen_i ? exc_code_i : code_q;
        badvaddr_d  = (exc_happen_i && exc_load_addr_i) ? exc_badvaddr_i : badvaddr_q;
        ce_d        = (exc_happen_i && exc_load_ce_i) ? exc_ce_i : ce_q;
        ebase_d     = wr_ebase ? ((ebase_q & ~EBASE_MASK) | (wr_data_i & EBASE_MASK)) : ebase_q;
        errorepc_d  = wr_errorepc ? wr_data_i : errorepc_q;
        lladdr_d    = ll_set_i ? ll_addr_i : lladdr_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            status_q   <= 32'h0040_0004;
            epc_q      <= '0;
            ebase_q    <= 32'h8000_0000 | 32'(CPU_NUMBER);
            lladdr_q   <= '0;
            errorepc_q <= '0;
            div_q      <= '0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            iv_q       <= 1'b0;
            ce_q       <= '0;
            ip_q       <= '0;
            code_q     <= '0;
        end else begin
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            status_q   <= status_d;
            epc_q      <= epc_d;
            ebase_q    <= ebase_d;
            lladdr_q   <= lladdr_d;
            errorepc_q <= errorepc_d;
            div_q      <= div_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            iv_q       <= iv_d;
            ce_q       <= ce_d;
            ip_q       <= ip_d;
            code_q     <= code_d;
        end
    end

    always_comb begin
        rd_data_o = '0;
        case ({rd_rd_i, rd_sel_i})
            {5'd8,  3'd0}: rd_data_o = badvaddr_q;
            {5'd9,  3'd0}: rd_data_o = count_q;
            {5'd11, 3'd0}: rd_data_o = compare_q;
            {5'd12, 3'd0}: rd_data_o = status_q;
            {5'd13, 3'd0}: rd_data_o = cause;
            {5'd14, 3'd0}: rd_data_o = epc_q;
            {5'd15, 3'd1}: rd_data_o = ebase_q;
            {5'd17, 3'd0}: rd_data_o = lladdr_q;
            {5'd30, 3'd0}: rd_data_o = errorepc_q;
            default:       rd_data_o = '0;
        endcase
    end

    assign int_req_o     = status_q[0] && !exl && !erl && |(ip_q & status_q[15:8]);
    // Interrupt reports with IV set use the dedicated +0x200 entry.
    assign exc_vector_o  = (status_q[22] ? 32'hBFC0_0200 : {ebase_q[31:12], 12'h000}) +
                           {20'd0, (iv_q && code_q == 5'd0) ? 12'h200 : 12'h180};
    assign eret_target_o = erl ? errorepc_q : epc_q;
    assign kernel_mode_o = !status_q[4] || exl || erl;
    assign status_o      = status_q;
    assign epc_o         = epc_q;
    assign errorepc_o    = errorepc_q;
    assign ebase_o       = ebase_q;
endmodule

// File: tb/tb_cop0_reg_bank.sv
// tb_cop0_reg_bank: directed and randomized checks of cop0_reg_bank against a field-level reference model.
module tb_cop0_reg_bank;
    localparam logic [9:0] CPU = 10'h2A;
    localparam int         DIV = 2;

    logic        clk = 1'b0, reset_i = 1'b1;
    logic        exc_happen = 0, exc_in_bd = 0, exc_load_addr = 0, exc_load_ce = 0, eret = 0, wr_en = 0, ll_set = 0;
    logic [4:0]  exc_code = 0, wr_rd = 0, rd_rd = 0;
    logic [2:0]  wr_sel = 0, rd_sel = 0;
    logic [1:0]  exc_ce = 0;
    logic [5:0]  hw_int = 0;
    logic [31:0] exc_epc = 0, exc_badvaddr = 0, wr_data = 0, ll_addr = 0;
    logic [31:0] rd_data, exc_vector, eret_target, status_o, epc_o, errorepc_o, ebase_o;
    logic        int_req, kernel_mode;
    int          n_tests = 0, n_fail = 0;

    logic [31:0] m_status, m_epc, m_errorepc, m_ebase, m_badv, m_ll, m_compare, m_base;
    logic        m_bd, m_ti, m_iv;
    logic [1:0]  m_ce;
    logic [7:0]  m_ip;
    logic [4:0]  m_code;
    int unsigned m_ticks;

    cop0_reg_bank #(.CPU_NUMBER(CPU), .COUNT_DIV(DIV)) dut (
        .clk_i(clk), .reset_i(reset_i), .exc_happen_i(exc_happen), .exc_in_bd_i(exc_in_bd),
        .exc_code_i(exc_code), .exc_epc_i(exc_epc), .exc_load_addr_i(exc_load_addr),
        .exc_badvaddr_i(exc_badvaddr), .exc_load_ce_i(exc_load_ce), .exc_ce_i(exc_ce), .eret_i(eret),
        .wr_en_i(wr_en), .wr_rd_i(wr_rd), .wr_sel_i(wr_sel), .wr_data_i(wr_data),
        .rd_rd_i(rd_rd), .rd_sel_i(rd_sel), .rd_data_o(rd_data), .hw_int_i(hw_int),
        .ll_set_i(ll_set), .ll_addr_i(ll_addr), .int_req_o(int_req), .exc_vector_o(exc_vector),
        .eret_target_o(eret_target), .status_o(status_o), .epc_o(epc_o), .errorepc_o(errorepc_o),
        .ebase_o(ebase_o), .kernel_mode_o(kernel_mode)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] m_count();
        return m_base + 32'(m_ticks / DIV);
    endfunction

    function automatic logic [31:0] m_cause();
        return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ce) << 28) | (32'(m_iv) << 23) |
               (32'(m_ip) << 8) | (32'(m_code) << 2);
    endfunction

    function automatic logic [31:0] m_read(logic [4:0] r, logic [2:0] s);
        if (r == 15 && s == 1) return m_ebase;
        if (s != 0) return 32'h0;
        case (r)
            8:       return m_badv;
            9:       return m_count();
            11:      return m_compare;
            12:      return m_status;
            13:      return m_cause();
            14:      return m_epc;
            17:      return m_ll;
            30:      return m_errorepc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [7:0] pick(int k);
        case (k)
            0:       return {5'd8, 3'd0};
            1:       return {5'd9, 3'd0};
            2:       return {5'd11, 3'd0};
            3:       return {5'd12, 3'd0};
            4:       return {5'd13, 3'd0};
            5:       return {5'd14, 3'd0};
            6:       return {5'd15, 3'd1};
            7:       return {5'd17, 3'd0};
            8:       return {5'd30, 3'd0};
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic model_reset();
        m_status = 32'h0040_0004; m_ebase = 32'h8000_0000 | 32'(CPU);
        m_epc = 0; m_errorepc = 0; m_badv = 0; m_ll = 0; m_compare = 0; m_base = 0; m_ticks = 0;
        m_bd = 0; m_ti = 0; m_iv = 0; m_ce = 0; m_ip = 0; m_code = 0;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(string tag, logic [4:0] r, logic [2:0] s, logic [31:0] exp);
        rd_rd = r; rd_sel = s; #1;
        chk(tag, rd_data, exp);
    endtask

    task automatic chk_all();
        chk("status", status_o, m_status);
        chk("epc", epc_o, m_epc);
        chk("errorepc", errorepc_o, m_errorepc);
        chk("ebase", ebase_o, m_ebase);
        chk("int_req", 32'(int_req),
            32'(m_status[0] && !m_status[1] && !m_status[2] && (m_ip & m_status[15:8]) != 0));
        chk("exc_vector", exc_vector, (m_status[22] ? 32'hBFC0_0200 : (m_ebase & 32'hFFFF_F000)) +
            ((m_iv && m_code == 0) ? 32'h200 : 32'h180));
        chk("eret_target", eret_target, m_status[2] ? m_errorepc : m_epc);
        chk("kernel_mode", 32'(kernel_mode), 32'(!m_status[4] || m_status[1] || m_status[2]));
        #1;
        chk("rd_data", rd_data, m_read(rd_rd, rd_sel));
    endtask

    // Applies the current inputs to the model, then advances the DUT by one edge.
    task automatic tick();
        bit exl = m_status[1], erl = m_status[2], old_ti = m_ti, hit = 0;
        bit w_cnt = wr_en && wr_rd == 9 && wr_sel == 0;
        bit w_cmp = wr_en && wr_rd == 11 && wr_sel == 0;
        bit w_st = wr_en && wr_rd == 12 && wr_sel == 0;
        bit w_cause = wr_en && wr_rd == 13 && wr_sel == 0;
        bit w_epc = wr_en && wr_rd == 14 && wr_sel == 0;
        bit w_eb = wr_en && wr_rd == 15 && wr_sel == 1;
        bit w_eepc = wr_en && wr_rd == 30 && wr_sel == 0;
        logic [31:0] old_cmp = m_compare;
        if (w_cnt) begin
            m_base = wr_data; m_ticks = 0;
        end else begin
            m_ticks++;
            hit = (m_ticks % DIV == 0) && m_count() == old_cmp;
        end
        if (w_cmp) begin m_compare = wr_data; m_ti = 0; end
        else if (hit) m_ti = 1;
        m_ip = {old_ti | hw_int[5], hw_int[4:0], m_ip[1:0]};
        if (exc_happen) begin
            if (!exl) begin m_epc = exc_epc; m_bd = exc_in_bd; end
            m_status[1] = 1'b1; m_code = exc_code;
            if (exc_load_addr) m_badv = exc_badvaddr;
            if (exc_load_ce) m_ce = exc_ce;
        end else begin
            if (eret) begin
                if (erl) m_status[2] = 1'b0; else m_status[1] = 1'b0;
            end else if (w_st) m_status = wr_data & 32'hF040_FF17;
            if (w_cause) begin m_iv = wr_data[23]; m_ip[1:0] = wr_data[9:8]; end
            if (w_epc) m_epc = wr_data;
        end
        if (w_eb) m_ebase[29:12] = wr_data[29:12];
        if (w_eepc) m_errorepc = wr_data;
        if (ll_set) m_ll = ll_addr;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        exc_happen = 0; exc_load_addr = 0; exc_load_ce = 0; eret = 0; wr_en = 0; ll_set = 0;
    endtask

    task automatic wr(logic [4:0] r, logic [2:0] s, logic [31:0] d);
        wr_en = 1; wr_rd = r; wr_sel = s; wr_data = d;
        tick(); idle();
    endtask

    task automatic exc(logic [4:0] code, logic [31:0] epc, logic bd, logic ld, logic [31:0] badv);
        exc_happen = 1; exc_code = code; exc_epc = epc; exc_in_bd = bd; exc_load_addr = ld; exc_badvaddr = badv;
        tick(); idle();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_i = 0;
        chk_rd("reset_status", 12, 0, 32'h0040_0004);
        chk_rd("reset_ebase", 15, 1, 32'h8000_0000 | 32'(CPU));
        chk("reset_int_req", 32'(int_req), 0);
        chk("reset_vector", exc_vector, 32'hBFC0_0380);
        chk_all();

        wr(11, 0, 5);
        wr(12, 0, 32'h0000_8001);
        wr(9, 0, 0);
        repeat (10) tick();
        chk_rd("timer_count", 9, 0, 5);
        chk_rd("timer_ti", 13, 0, m_cause());
        chk("timer_ti_bit", 32'(rd_data[30]), 1);
        chk("timer_no_irq_yet", 32'(int_req), 0);
        tick();
        chk("timer_irq", 32'(int_req), 1);
        wr(11, 0, 6);
        chk_rd("timer_ti_clr", 13, 0, m_cause());
        chk("timer_ti_clr_bit", 32'(rd_data[30]), 0);
        chk_all();

        exc(4, 32'h8000_1000, 1, 1, 32'h1234_5673);
        exc(5, 32'h8000_2000, 0, 0, 32'hDEAD_BEEF);
        chk("nest_epc", epc_o, 32'h8000_1000);
        chk_rd("nest_cause", 13, 0, m_cause());
        chk("nest_bd", 32'(rd_data[31]), 1);
        chk("nest_code", 32'(rd_data[6:2]), 5);
        chk_rd("nest_badv", 8, 0, 32'h1234_5673);

        wr(30, 0, 32'hBFC0_0000);
        wr(12, 0, 32'h0000_0006);
        chk("eret1_target", eret_target, 32'hBFC0_0000);
        eret = 1; tick(); idle();
        chk("eret1_erl", 32'(status_o[2:1]), 1);
        chk("eret2_target", eret_target, 32'h8000_1000);
        eret = 1; tick(); idle();
        chk("eret2_exl", 32'(status_o[2:1]), 0);
        chk_all();

        wr(12, 0, 32'h0000_8011);
        wr_en = 1; wr_rd = 12; wr_sel = 0; wr_data = 32'hFFFF_FFFF;
        exc(3, 32'h8000_4000, 0, 0, 0);
        chk("same_cycle_status", status_o, 32'h0000_8013);
        chk_all();

        wr(12, 0, 0);
        wr(15, 1, 32'h8000_3000);
        wr(13, 0, 32'h0080_0000);
        exc(0, 32'h8000_5000, 0, 0, 0);
        chk("vec_iv_int", exc_vector, 32'h8000_3200);
        exc(8, 32'h8000_6000, 0, 0, 0);
        chk("vec_iv_other", exc_vector, 32'h8000_3180);
        chk_all();

        for (int i = 0; i < 400; i++) begin
            exc_happen = ($urandom_range(0, 7) == 0);
            exc_in_bd = 1'($urandom); exc_code = 5'($urandom); exc_epc = $urandom;
            exc_load_addr = 1'($urandom); exc_badvaddr = $urandom;
            exc_load_ce = 1'($urandom); exc_ce = 2'($urandom);
            eret = ($urandom_range(0, 9) == 0);
            wr_en = ($urandom_range(0, 2) == 0);
            {wr_rd, wr_sel} = pick($urandom_range(0, 9));
            wr_data = (wr_rd == 11 && wr_sel == 0) ? m_count() + $urandom_range(1, 3) : $urandom;
            hw_int = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
            ll_set = 1'($urandom); ll_addr = $urandom;
            {rd_rd, rd_sel} = pick($urandom_range(0, 9));
            tick();
            chk_all();
        end
        idle(); hw_int = 0;

        @(posedge clk); #3 reset_i = 1; #1;
        model_reset();
        chk("async_status", status_o, 32'h0040_0004);
        chk("async_epc", epc_o, 0);
        chk_rd("async_count", 9, 0, 0);
        @(posedge clk); #1 reset_i = 0;
        repeat (5) begin tick(); chk_all(); end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
